// File: rtl/cb_sequencer.sv
// T-step/M-cycle timing and CB-prefix front end: latches opcode bytes, fetches
// the CB opcode into Z, and keeps the CB microcode active until it finishes.
module cb_sequencer #(
  parameter logic [7:0] PREFIX_OPCODE = 8'hCB,
  parameter logic [7:0] RESET_OPCODE  = 8'h00
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Enable,
  input  logic [7:0] i_Bus_Data,
  input  logic       i_Main_IR_Fetch,
  input  logic       i_Disable_CB,
  output logic [3:0] o_Cycle_Step,
  output logic [7:0] o_Cycle_Count,
  output logic [7:0] o_IR,
  output logic [7:0] o_Z,
  output logic       o_CB_Active,
  output logic       o_CB_Fetch,
  output logic       o_Count_Overflow
);

  typedef enum logic [1:0] {
    NORMAL   = 2'd0,
    CB_FETCH = 2'd1,
    CB_EXEC  = 2'd2
  } state_t;

  localparam int unsigned STEP_W  = 4;
  localparam int unsigned COUNT_W = 8;

  state_t             state, state_nxt;
  logic [STEP_W-1:0]  step_nxt;
  logic [COUNT_W-1:0] count_nxt;
  logic [7:0]         ir_nxt;
  logic [7:0]         z_nxt;
  logic               ovf_nxt;
  logic               reload;
  logic               m_end;
  logic               bus_is_prefix;

  assign m_end         = i_Enable & o_Cycle_Step[STEP_W-1];
  assign bus_is_prefix = (i_Bus_Data == PREFIX_OPCODE);

  // Next-state, opcode latching and counter update; everything moves on M-end edges except the step ring.
  always_comb begin
    state_nxt = state;
    step_nxt  = o_Cycle_Step;
    count_nxt = o_Cycle_Count;
    ir_nxt    = o_IR;
    z_nxt     = o_Z;
    ovf_nxt   = o_Count_Overflow;
    reload    = 1'b0;

    if (i_Enable) begin
      step_nxt = {o_Cycle_Step[STEP_W-2:0], o_Cycle_Step[STEP_W-1]};
    end

    if (m_end) begin
      case (state)
        NORMAL: begin
          if (i_Main_IR_Fetch) begin
            reload    = 1'b1;
            ir_nxt    = i_Bus_Data;
            state_nxt = bus_is_prefix ? CB_FETCH : NORMAL;
          end
        end
        CB_FETCH: begin
          reload    = 1'b1;
          z_nxt     = i_Bus_Data;
          state_nxt = CB_EXEC;
        end
        CB_EXEC: begin
          if (i_Disable_CB) begin
            reload    = 1'b1;
            ir_nxt    = i_Bus_Data;
            state_nxt = bus_is_prefix ? CB_FETCH : NORMAL;
          end
        end
        default: begin
          state_nxt = NORMAL;
        end
      endcase

      // Saturate at the top M-cycle and flag it; only reset clears the flag.
      if (reload) begin
        count_nxt = COUNT_W'(1);
      end else if (o_Cycle_Count[COUNT_W-1]) begin
        ovf_nxt = 1'b1;
      end else begin
        count_nxt = {o_Cycle_Count[COUNT_W-2:0], 1'b0};
      end
    end
  end

  // State and output registers; CB enables are registered decodes of the next state.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state            <= NORMAL;
      o_Cycle_Step     <= STEP_W'(1);
      o_Cycle_Count    <= COUNT_W'(1);
      o_IR             <= RESET_OPCODE;
      o_Z              <= RESET_OPCODE;
      o_CB_Active      <= 1'b0;
      o_CB_Fetch       <= 1'b0;
      o_Count_Overflow <= 1'b0;
    end else begin
      state            <= state_nxt;
      o_Cycle_Step     <= step_nxt;
      o_Cycle_Count    <= count_nxt;
      o_IR             <= ir_nxt;
      o_Z              <= z_nxt;
      o_CB_Active      <= (state_nxt == CB_EXEC);
      o_CB_Fetch       <= (state_nxt == CB_FETCH);
      o_Count_Overflow <= ovf_nxt;
    end
  end

endmodule

// File: doc/cb_sequencer.md
Name: cb_sequencer

Overview:
- Timing and prefix front end for the CB-prefixed instruction path.
- Generates the one-hot T-step and M-cycle counters consumed by the CB microcode and main microcode.
- Latches fetched opcode bytes; detects the 0xCB prefix, fetches the CB opcode byte into Z, then holds the CB microcode active until it signals completion.
- Sits directly upstream of the CB microcode stage and drives its active, cycle-step, cycle-count and Z inputs.

Parameters:
- PREFIX_OPCODE, 8'hCB, opcode byte that selects the CB path.
- RESET_OPCODE, 8'h00, value loaded into o_IR and o_Z on reset (NOP).

Ports:
- i_Clk  input  1  system clock, rising edge.
- i_Reset  input  1  asynchronous, active-high reset.
- i_Enable  input  1  CPU tick; all state advances only when high.
- i_Bus_Data  input  8  data bus, sampled on fetch edges.
- i_Main_IR_Fetch  input  1  main microcode: current M-cycle is the overlapped opcode fetch.
- i_Disable_CB  input  1  CB microcode: final step of the CB instruction.
- o_Cycle_Step  output  4  one-hot T-step, T1=bit0 … T4=bit3.
- o_Cycle_Count  output  8  one-hot M-cycle index within the current instruction.
- o_IR  output  8  latched main opcode.
- o_Z  output  8  latched CB opcode byte.
- o_CB_Active  output  1  CB microcode enable.
- o_CB_Fetch  output  1  high during the M-cycle that fetches the CB opcode byte (drives PC address out / increment).
- o_Count_Overflow  output  1  sticky error flag.

Behaviour:
- Reset (async, any time, including mid-instruction):
  - o_Cycle_Step=4'b0001, o_Cycle_Count=8'h01, o_IR=o_Z=RESET_OPCODE.
  - o_CB_Active=0, o_CB_Fetch=0, o_Count_Overflow=0, state=NORMAL.
- i_Enable low: every register holds, including the step counter.
- Step counter:
  - Each enabled edge rotates left: 0001→0010→0100→1000→0001.
  - An "M-end edge" is an enabled edge with o_Cycle_Step[3]=1.
- Count counter, updated on M-end edges only:
  - Reloads 8'h01 if the current M-cycle is a fetch: NORMAL with i_Main_IR_Fetch=1, CB_FETCH, or CB_EXEC with i_Disable_CB=1.
  - Otherwise shifts left by 1.
  - At 8'h80 with no reload, count holds 8'h80 and o_Count_Overflow sets; it clears only on reset.
- State machine, all transitions on M-end edges:
  - NORMAL, i_Main_IR_Fetch=1: o_IR←i_Bus_Data. If that byte equals PREFIX_OPCODE, go to CB_FETCH; else stay NORMAL. i_Disable_CB is ignored.
  - CB_FETCH: o_CB_Fetch=1 for the whole M-cycle. At its M-end edge, o_Z←i_Bus_Data, o_CB_Active←1, count←8'h01, go to CB_EXEC. i_Main_IR_Fetch is ignored.
  - CB_EXEC: o_CB_Active=1. i_Main_IR_Fetch is ignored. On an M-end edge with i_Disable_CB=1:
    - o_IR←i_Bus_Data (overlapped fetch of the next opcode), o_CB_Active←0.
    - Go to CB_FETCH if the byte equals PREFIX_OPCODE (back-to-back CB instructions, no NORMAL cycle in between); else go to NORMAL.
  - i_Disable_CB while not on an M-end edge has no effect.
- o_Z holds its value outside CB_FETCH edges. o_IR holds outside fetch edges.
- o_CB_Fetch and o_CB_Active are registered state decodes. They are never high together.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset then 8 enabled clocks, no fetch → Step cycles 0001,0010,0100,1000 twice; Count 01→02 after edge 4, →04 after edge 8.
- NORMAL with i_Main_IR_Fetch=1 and bus=8'h3E at the M-end edge → o_IR=3E, Count=01, o_CB_Active stays 0.
- Fetch 8'hCB → next M-cycle o_CB_Fetch=1. Bus=8'h46 at its M-end → o_Z=46, o_CB_Active=1, Count=01. Hold 2 M-cycles, then i_Disable_CB with bus=8'h00 → o_IR=00, o_CB_Active=0, state NORMAL.
- In CB_EXEC, i_Disable_CB with bus=8'hCB, then bus=8'h11 → CB_FETCH entered directly, then o_Z=11, o_CB_Active=1 again.
- 9 M-cycles with no fetch → Count reaches 80, stays 80, o_Count_Overflow=1 until i_Reset.
- Assert i_Reset mid-CB_FETCH at Step=0100; drop i_Enable for 3 clocks in CB_EXEC → reset: all outputs at reset values immediately (async); i_Enable low: Step, Count, o_Z frozen.
